shift_cmd_queue: RTL and testbench
==================================

# shift_cmd_queue

Command queue directly upstream of the barrel shifter. It buffers shift commands {data, amount, type} from the issuing logic in a DEPTH-entry FIFO. It presents the head command to the shifter's `data_in`/`shift_amt`/`shift_type` inputs under a valid/ready handshake, decoupling command producers from shifter consumption.

## Interface
- `WIDTH`, default 8: data width. Must match the shifter's WIDTH.
- `DEPTH`, default 4: FIFO entries. Power of two, ≥2.
- `clk`  input  1  clock; all state updates on rising edge.
- `rst`  input  1  asynchronous, active-high reset.
- `in_valid`  input  1  producer has a command.
- `in_ready`  output  1  queue can accept; equals !full.
- `in_data`  input  WIDTH  operand.
- `in_amt`  input  $clog2(WIDTH)  shift amount.
- `in_type`  input  3  shift type: 000 LSL, 001 LSR, 010 ASR, 011 ROL, 100 ROR.
- `out_valid`  output  1  head command present; equals !empty.
- `out_ready`  input  1  shifter side consumes head.
- `out_data`  output  WIDTH  head operand.
- `out_amt`  output  $clog2(WIDTH)  head amount.
- `out_type`  output  3  head type.
- `count`  output  $clog2(DEPTH+1)  occupied entries.
- `full`  output  1  count == DEPTH.
- `empty`  output  1  count == 0.
- `err`  output  1  sticky illegal-type flag (see Configuration).

## Operation
- Push = in_valid && in_ready. Pop = out_valid && out_ready.
- Push writes {in_data, in_amt, in_type} at wr_ptr; wr_ptr increments mod DEPTH.
- Pop advances rd_ptr mod DEPTH.
- count: +1 on push only, −1 on pop only, unchanged on simultaneous push+pop.
- Pointers wrap from DEPTH−1 to 0 with no lost or duplicated entry.
- Full: in_ready=0, in_valid ignored, no bypass. A push is not accepted in the same cycle as a pop from full.
- Empty: out_valid=0. out_* show the entry at rd_ptr and are don't-care.
- out_* driven combinationally from the storage entry at rd_ptr. They are stable while out_valid && !out_ready.
- Order strictly FIFO. Type/amount/data are never modified.
- Reset (async assert, any time, including mid-burst):
  - pointers, count, and err go to 0; storage is cleared to 0.
  - out_valid=0, empty=1, full=0, in_ready=1, count=0, out_data/out_amt/out_type=0.
  - No push or pop occurs while rst is high.

## Timing
- Pushed command visible at out_* the cycle after the push edge; no same-cycle fall-through.
- Throughput: one push and one pop per cycle sustained when 0<count<DEPTH.
- in_ready, full, empty, count, and out_valid change only after a clock edge (or async reset). They have no combinational dependence on in_valid/out_ready.
- Deassertion of rst: first push can be accepted on the first rising edge with rst low.

## Configuration
- Macro `SHIFT_CMD_QUEUE_TYPE_CHECK_EN`.
- Defined:
  - A push with in_type in {101, 110, 111} is accepted (handshake completes) but not stored; count and wr_ptr are unchanged.
  - err is set the following cycle and held until rst.
- Undefined: all types are stored unchecked; err is tied 0.

## Structure
- Shared package `shift_pkg`:
  - shift-type encodings (SHIFT_LSL=3'b000 … SHIFT_ROR=3'b100);
  - packed command struct {data, amt, type};
  - function `shift_type_legal`.
- Sub-module `shift_cmd_fifo_mem`: DEPTH×(WIDTH+$clog2(WIDTH)+3) register array with write port and async read port. Pointer, count, and flag logic stay in the top.

## Test plan
- Reset then single command 8'b00001111, amt 2, type 000 with out_ready=1 → out_valid rises one cycle after push with the same fields; count returns to 0 after pop.
- Push 4 commands (DEPTH=4) with out_ready=0 → full=1, in_ready=0, count=4; a 5th in_valid is ignored. Then drain → order preserved: ROL 11000011/3, ROR 11000011/3, LSR 11110000/2, ASR 11110000/2.
- Continuous push+pop for 10 cycles at count=2 → count stays 2, pointers wrap, outputs match the push sequence delayed.
- out_ready=0 stall for 3 cycles with out_valid=1 → out_data/out_amt/out_type constant across the stall.
- rst asserted mid-burst at count=3 → outputs go to their reset values immediately (before next edge); after release, the first new push is the next output.
- With SHIFT_CMD_QUEUE_TYPE_CHECK_EN: push type 111 then type 001 → only the 001 command is output, count peaks at 1, err=1 until rst. Without the macro: both are output, err=0.

Source files
------------

// File: rtl/shift_pkg.sv
// Shared shift-command definitions: type encodings, a default-width command
// struct and the legality check for the shift-type field.
package shift_pkg;

  localparam int unsigned SHIFT_TYPE_W    = 3;
  localparam int unsigned SHIFT_DEF_WIDTH = 8;

  typedef enum logic [SHIFT_TYPE_W-1:0] {
    SHIFT_LSL = 3'b000,
    SHIFT_LSR = 3'b001,
    SHIFT_ASR = 3'b010,
    SHIFT_ROL = 3'b011,
    SHIFT_ROR = 3'b100
  } shift_type_e;

  typedef struct packed {
    logic [SHIFT_DEF_WIDTH-1:0]         data;
    logic [$clog2(SHIFT_DEF_WIDTH)-1:0] amt;
    shift_type_e                        typ;
  } shift_cmd_t;

  // Codes 101..111 have no shifter operation behind them.
  function automatic logic shift_type_legal(input logic [SHIFT_TYPE_W-1:0] t);
    return t <= SHIFT_TYPE_W'(SHIFT_ROR);
  endfunction

endpackage

// File: rtl/shift_cmd_fifo_mem.sv
// Register-array storage for the command queue: one synchronous write port,
// one asynchronous read port, contents cleared by reset.
module shift_cmd_fifo_mem #(
  parameter int DW    = 14,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] waddr_i,
  input  logic [DW-1:0]            wdata_i,
  input  logic [$clog2(DEPTH)-1:0] raddr_i,
  output logic [DW-1:0]            rdata_o
);

  logic [DW-1:0] mem_q [DEPTH];

  // NOTE: the array is reset because the head outputs must read as zero
  // straight out of reset; that rules out a RAM macro for this storage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/shift_cmd_queue.sv
// Valid/ready command FIFO feeding the barrel shifter.
// Optional build macro SHIFT_CMD_QUEUE_TYPE_CHECK_EN drops illegal-type pushes and raises err.
module shift_cmd_queue
  import shift_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_data,
  input  logic [$clog2(WIDTH)-1:0]   in_amt,
  input  logic [2:0]                 in_type,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_data,
  output logic [$clog2(WIDTH)-1:0]   out_amt,
  output logic [2:0]                 out_type,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty,
  output logic                       err
);

  localparam int AMT_W = $clog2(WIDTH);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic [AMT_W-1:0] amt;
    shift_type_e      typ;
  } cmd_t;

  localparam int CMD_W = $bits(cmd_t);

  cmd_t             wr_cmd, rd_cmd;
  logic [CMD_W-1:0] rd_raw;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push, pop, store;

  // Flags come from registered count only, so they never depend on the handshake inputs.
  assign full      = (count_q == CNT_W'(DEPTH));
  assign empty     = (count_q == '0);
  assign in_ready  = !full;
  assign out_valid = !empty;
  assign count     = count_q;

  assign push   = in_valid && in_ready;
  assign pop    = out_valid && out_ready;
  assign wr_cmd = '{data: in_data, amt: in_amt, typ: shift_type_e'(in_type)};

`ifdef SHIFT_CMD_QUEUE_TYPE_CHECK_EN
  logic err_q;

  assign store = push && shift_type_legal(in_type);
  assign err   = err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                 err_q <= 1'b0;
    else if (push && !store) err_q <= 1'b1;
  end
`else
  assign store = push;
  assign err   = 1'b0;
`endif

  // NOTE: every next-state signal takes its hold value first, so no path
  // through this block can leave one unassigned and infer a latch.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (store) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)   rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({store, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // NOTE: state registers use non-blocking assignment so all of them update
  // from the same pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  shift_cmd_fifo_mem #(
    .DW    (CMD_W),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk     (clk),
    .rst     (rst),
    .we_i    (store),
    .waddr_i (wr_ptr_q),
    .wdata_i (wr_cmd),
    .raddr_i (rd_ptr_q),
    .rdata_o (rd_raw)
  );

  assign rd_cmd   = cmd_t'(rd_raw);
  assign out_data = rd_cmd.data;
  assign out_amt  = rd_cmd.amt;
  assign out_type = rd_cmd.typ;

endmodule

// File: tb/tb_shift_cmd_queue.sv
// Self-checking bench for shift_cmd_queue: directed scenarios plus random
// traffic against a queue-based reference model.
module tb_shift_cmd_queue;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid, in_ready, out_valid, out_ready;
  logic [7:0] in_data, out_data;
  logic [2:0] in_amt, out_amt, in_type, out_type;
  logic [2:0] count;
  logic       full, empty, err;

  shift_cmd_queue #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_amt    (in_amt),
    .in_type   (in_type),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_amt   (out_amt),
    .out_type  (out_type),
    .count     (count),
    .full      (full),
    .empty     (empty),
    .err       (err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] d;
    logic [2:0] a;
    logic [2:0] t;
  } m_cmd_t;

  m_cmd_t m_q[$];
  logic   m_err;
  int     tests = 0;
  int     fails = 0;

`ifdef SHIFT_CMD_QUEUE_TYPE_CHECK_EN
  localparam bit CHECK_EN = 1'b1;
`else
  localparam bit CHECK_EN = 1'b0;
`endif

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_state(input string tag);
    check({tag, ".count"}, 32'(count), 32'(m_q.size()));
    check({tag, ".empty"}, 32'(empty), 32'(m_q.size() == 0));
    check({tag, ".full"}, 32'(full), 32'(m_q.size() == DEPTH));
    check({tag, ".in_ready"}, 32'(in_ready), 32'(m_q.size() != DEPTH));
    check({tag, ".out_valid"}, 32'(out_valid), 32'(m_q.size() != 0));
    check({tag, ".err"}, 32'(err), 32'(m_err));
    if (m_q.size() > 0) begin
      check({tag, ".data"}, 32'(out_data), 32'(m_q[0].d));
      check({tag, ".amt"}, 32'(out_amt), 32'(m_q[0].a));
      check({tag, ".type"}, 32'(out_type), 32'(m_q[0].t));
    end
  endtask

  // One clock: drive inputs at the falling edge, predict, check at the next falling edge.
  task automatic cycle(input string tag, input logic v, input logic [7:0] d,
                       input logic [2:0] a, input logic [2:0] t, input logic r);
    bit do_push, do_pop, legal;
    in_valid  = v;
    in_data   = d;
    in_amt    = a;
    in_type   = t;
    out_ready = r;
    do_push = v && (m_q.size() < DEPTH);
    do_pop  = r && (m_q.size() > 0);
    legal   = !CHECK_EN || (t <= 3'd4);
    @(posedge clk);
    if (do_pop) void'(m_q.pop_front());
    if (do_push && legal) m_q.push_back('{d: d, a: a, t: t});
    if (do_push && !legal) m_err = 1'b1;
    @(negedge clk);
    check_state(tag);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, ".out_valid"}, 32'(out_valid), 32'd0);
    check({tag, ".empty"}, 32'(empty), 32'd1);
    check({tag, ".full"}, 32'(full), 32'd0);
    check({tag, ".in_ready"}, 32'(in_ready), 32'd1);
    check({tag, ".count"}, 32'(count), 32'd0);
    check({tag, ".out_data"}, 32'(out_data), 32'd0);
    check({tag, ".out_amt"}, 32'(out_amt), 32'd0);
    check({tag, ".out_type"}, 32'(out_type), 32'd0);
    check({tag, ".err"}, 32'(err), 32'd0);
  endtask

  // Reset asserted away from the clock edge; outputs must clear before any edge.
  task automatic apply_reset(input string tag);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    rst = 1'b1;
    #1;
    check_reset_values(tag);
    m_q.delete();
    m_err = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic [7:0] d;
    rst = 1'b1;
    in_valid = 1'b0; in_data = '0; in_amt = '0; in_type = '0; out_ready = 1'b0;
    m_err = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_values("por");
    rst = 1'b0;

    // Single command: visible one cycle after the push, then popped.
    cycle("t1_push", 1'b1, 8'b0000_1111, 3'd2, 3'b000, 1'b1);
    check("t1.data_const", 32'(out_data), 32'h0F);
    check("t1.amt_const", 32'(out_amt), 32'd2);
    cycle("t1_pop", 1'b0, 8'h00, 3'd0, 3'd0, 1'b1);
    check("t1.count_zero", 32'(count), 32'd0);

    // Fill to full, ignored extra push, then drain in order.
    cycle("t2_p0", 1'b1, 8'b1100_0011, 3'd3, 3'b011, 1'b0);
    cycle("t2_p1", 1'b1, 8'b1100_0011, 3'd3, 3'b100, 1'b0);
    cycle("t2_p2", 1'b1, 8'b1111_0000, 3'd2, 3'b001, 1'b0);
    cycle("t2_p3", 1'b1, 8'b1111_0000, 3'd2, 3'b010, 1'b0);
    check("t2.full", 32'(full), 32'd1);
    check("t2.in_ready", 32'(in_ready), 32'd0);
    check("t2.count4", 32'(count), 32'd4);
    cycle("t2_p4", 1'b1, 8'hAA, 3'd1, 3'b000, 1'b0);
    check("t2.head_after_5th", 32'(out_type), 32'b011);
    cycle("t2_d0", 1'b0, 8'h00, 3'd0, 3'd0, 1'b1);
    check("t2.second_type", 32'(out_type), 32'b100);
    cycle("t2_d1", 1'b0, 8'h00, 3'd0, 3'd0, 1'b1);
    check("t2.third", 32'({out_data, out_type}), 32'({8'b1111_0000, 3'b001}));
    cycle("t2_d2", 1'b0, 8'h00, 3'd0, 3'd0, 1'b1);
    check("t2.fourth", 32'({out_data, out_type}), 32'({8'b1111_0000, 3'b010}));
    cycle("t2_d3", 1'b0, 8'h00, 3'd0, 3'd0, 1'b1);
    check("t2.drained", 32'(empty), 32'd1);

    // Hold count at 2 with simultaneous push+pop; pointers wrap.
    cycle("t3_pre0", 1'b1, 8'h11, 3'd1, 3'd0, 1'b0);
    cycle("t3_pre1", 1'b1, 8'h22, 3'd2, 3'd1, 1'b0);
    for (int i = 0; i < 10; i++) begin
      d = 8'($urandom);
      cycle("t3_stream", 1'b1, d, 3'($urandom), 3'($urandom_range(0, 4)), 1'b1);
      check("t3.count2", 32'(count), 32'd2);
    end

    // Stall: head fields must hold while out_ready is low.
    for (int i = 0; i < 3; i++) cycle("t4_stall", 1'b0, 8'h00, 3'd0, 3'd0, 1'b0);
    while (m_q.size() > 0) cycle("t4_drain", 1'b0, 8'h00, 3'd0, 3'd0, 1'b1);

    // Reset mid-burst at count 3, then first push after release is next output.
    for (int i = 0; i < 3; i++)
      cycle("t5_fill", 1'b1, 8'(8'h30 + i), 3'(i), 3'(i), 1'b0);
    check("t5.count3", 32'(count), 32'd3);
    apply_reset("t5_rst");
    cycle("t5_post", 1'b1, 8'h5A, 3'd5, 3'b011, 1'b0);
    check("t5.first_data", 32'(out_data), 32'h5A);
    cycle("t5_pop", 1'b0, 8'h00, 3'd0, 3'd0, 1'b1);

    // Illegal type followed by a legal one.
    apply_reset("t6_rst");
    cycle("t6_bad", 1'b1, 8'hE7, 3'd4, 3'b111, 1'b0);
    cycle("t6_good", 1'b1, 8'h3C, 3'd1, 3'b001, 1'b0);
    check("t6.count", 32'(count), CHECK_EN ? 32'd1 : 32'd2);
    check("t6.err", 32'(err), CHECK_EN ? 32'd1 : 32'd0);
    while (m_q.size() > 0) cycle("t6_drain", 1'b0, 8'h00, 3'd0, 3'd0, 1'b1);
    cycle("t6_idle", 1'b0, 8'h00, 3'd0, 3'd0, 1'b0);

    // Random traffic against the model.
    apply_reset("t7_rst");
    for (int i = 0; i < 300; i++)
      cycle("t7_rand", 1'($urandom), 8'($urandom), 3'($urandom),
            3'($urandom_range(0, 7)), 1'($urandom));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
